// File: rtl/axil2lb.sv
// axil2lb: AXI4-Lite slave to Local Bus master bridge with independent write/read paths and access timeout
module axil2lb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] axil_awaddr,
  input  logic              axil_awvalid,
  output logic              axil_awready,
  input  logic [DATA_W-1:0] axil_wdata,
  input  logic [STRB_W-1:0] axil_wstrb,
  input  logic              axil_wvalid,
  output logic              axil_wready,
  output logic [1:0]        axil_bresp,
  output logic              axil_bvalid,
  input  logic              axil_bready,
  input  logic [ADDR_W-1:0] axil_araddr,
  input  logic              axil_arvalid,
  output logic              axil_arready,
  output logic [DATA_W-1:0] axil_rdata,
  output logic [1:0]        axil_rresp,
  output logic              axil_rvalid,
  input  logic              axil_rready,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {W_IDLE, W_LB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LB, R_RESP} r_state_t;
  w_state_t w_st, w_nx;
  r_state_t r_st, r_nx;
  logic aw_got, w_got, aw_hs, w_hs, ar_hs, w_tmo, r_tmo;
  logic [CW-1:0] w_cnt, r_cnt;
  // The access is abandoned at the end of its TIMEOUT-th cycle in the LB state
  function automatic logic expired(input logic [CW-1:0] c);
    return TIMEOUT != 0 && int'(c) >= TIMEOUT - 1;
  endfunction
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
    return int'(c) >= TIMEOUT ? c : c + 1'b1;
  endfunction
  // Ready outputs are decoded from state, so they are masked while reset holds
  assign axil_awready = !rst && w_st == W_IDLE && !aw_got;
  assign axil_wready  = !rst && w_st == W_IDLE && !w_got;
  assign axil_arready = !rst && r_st == R_IDLE;
  assign aw_hs = axil_awvalid && axil_awready;
  assign w_hs  = axil_wvalid && axil_wready;
  assign ar_hs = axil_arvalid && axil_arready;
  assign lb_wen = w_st == W_LB;
  assign lb_ren = r_st == R_LB;
  assign axil_bvalid = w_st == W_RESP;
  assign axil_rvalid = r_st == R_RESP;
  assign w_tmo = expired(w_cnt);
  assign r_tmo = expired(r_cnt);
  always_comb begin
    w_nx = w_st;
    case (w_st)
      W_IDLE:  if ((aw_got || aw_hs) && (w_got || w_hs)) w_nx = W_LB;
      W_LB:    if (lb_wready || w_tmo) w_nx = W_RESP;
      W_RESP:  if (axil_bready) w_nx = W_IDLE;
      default: w_nx = W_IDLE;
    endcase
  end
  always_comb begin
    r_nx = r_st;
    case (r_st)
      R_IDLE:  if (ar_hs) r_nx = R_LB;
      R_LB:    if (lb_rvalid || r_tmo) r_nx = R_RESP;
      R_RESP:  if (axil_rready) r_nx = R_IDLE;
      default: r_nx = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_st       <= W_IDLE;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      lb_waddr   <= '0;
      lb_wdata   <= '0;
      lb_wstrb   <= '0;
      axil_bresp <= '0;
      w_cnt      <= '0;
    end else begin
      w_st <= w_nx;
      if (aw_hs) begin
        aw_got   <= 1'b1;
        lb_waddr <= axil_awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        lb_wdata <= axil_wdata;
        lb_wstrb <= axil_wstrb;
      end
      if (w_st == W_RESP && axil_bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      w_cnt <= w_st == W_LB ? bump(w_cnt) : '0;
      if (w_st == W_LB && w_nx == W_RESP) axil_bresp <= lb_wready ? 2'b00 : 2'b10;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st       <= R_IDLE;
      lb_raddr   <= '0;
      axil_rdata <= '0;
      axil_rresp <= '0;
      r_cnt      <= '0;
    end else begin
      r_st <= r_nx;
      if (ar_hs) lb_raddr <= axil_araddr;
      r_cnt <= r_st == R_LB ? bump(r_cnt) : '0;
      if (r_st == R_LB && r_nx == R_RESP) begin
        axil_rdata <= lb_rvalid ? lb_rdata : '0;
        axil_rresp <= lb_rvalid ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_axil2lb.sv
// tb_axil2lb: drives axil2lb against a behavioural register-map stub and checks responses against a reference model
module tb_axil2lb;
  localparam int TO = 4;
  logic clk = 1'b0, rst;
  logic [15:0] axil_awaddr, axil_araddr, lb_waddr, lb_raddr;
  logic [31:0] axil_wdata, axil_rdata, lb_wdata, lb_rdata;
  logic [3:0] axil_wstrb, lb_wstrb;
  logic [1:0] axil_bresp, axil_rresp;
  logic axil_awvalid, axil_awready, axil_wvalid, axil_wready, axil_bvalid, axil_bready;
  logic axil_arvalid, axil_arready, axil_rvalid, axil_rready;
  logic lb_wen, lb_wready, lb_ren, lb_rvalid;
  int errors = 0, checks = 0, pulses = 0, exp_pulses = 0, wc = 0, rc = 0;
  int wdly = 0, rdly = 0;
  bit stuck = 0, spur = 0;
  logic [31:0] regs_q [2] = '{32'h0, 32'h00ffff00};
  logic [31:0] mdl [2];

  always #5 clk = ~clk;

  axil2lb #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .axil_awaddr(axil_awaddr), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
    .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
    .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
    .axil_araddr(axil_araddr), .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
    .axil_rdata(axil_rdata), .axil_rresp(axil_rresp), .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen), .lb_wready(lb_wready),
    .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s, input logic [15:0] a);
    logic [31:0] r, m;
    r = o;
    m = a == 16'h0 ? 32'hffffffff : 32'h00ffff00;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return (r & m) | (o & ~m);
  endfunction

  // register-map stub: 0x0 fully writable, 0x4 only bytes 1..2 writable, others read 0
  assign lb_wready = spur || (lb_wen && !stuck && wc >= wdly);
  assign lb_rvalid = spur || (lb_ren && !stuck && rc >= rdly);
  assign lb_rdata  = lb_raddr == 16'h0 ? regs_q[0] : lb_raddr == 16'h4 ? regs_q[1] : 32'h0;
  always @(posedge clk) begin
    wc <= lb_wen ? wc + 1 : 0;
    rc <= lb_ren ? rc + 1 : 0;
    if (lb_wen && lb_wready) begin
      pulses <= pulses + 1;
      if (lb_waddr == 16'h0 || lb_waddr == 16'h4) regs_q[lb_waddr[2]] <= merge(regs_q[lb_waddr[2]], lb_wdata, lb_wstrb, lb_waddr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int ord, input int bdly,
                          output logic [1:0] resp, output int lat, output bit ok, output bit stall_ok);
    bit awd, wd, ah, wh;
    int t;
    awd = 0; wd = 0; t = 0; stall_ok = 1; resp = 2'b11;
    if (ord != 2) begin axil_wvalid = 1; axil_wdata = d; axil_wstrb = s; end
    if (ord != 1) begin axil_awvalid = 1; axil_awaddr = a; end
    while (!(awd && wd) && t < 20) begin
      ah = axil_awvalid && axil_awready;
      wh = axil_wvalid && axil_wready;
      @(posedge clk); #1; t++;
      if (ah) begin awd = 1; axil_awvalid = 0; end
      if (wh) begin wd = 1; axil_wvalid = 0; end
      if (wd && !awd) begin axil_awvalid = 1; axil_awaddr = a; end
      if (awd && !wd) begin axil_wvalid = 1; axil_wdata = d; axil_wstrb = s; end
    end
    axil_awvalid = 0; axil_wvalid = 0;
    ok = awd && wd;
    lat = 1;
    while (!axil_bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!axil_bvalid) ok = 0;
    resp = axil_bresp;
    for (int i = 0; i < bdly; i++) begin
      if (!(axil_bvalid && !axil_awready && !axil_wready)) stall_ok = 0;
      @(posedge clk); #1;
    end
    if (!axil_bvalid) stall_ok = 0;
    axil_bready = 1;
    @(posedge clk); #1;
    axil_bready = 0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
    bit done;
    int t;
    done = 0; t = 0;
    axil_arvalid = 1; axil_araddr = a;
    while (!done && t < 20) begin
      done = axil_arready;
      @(posedge clk); #1; t++;
    end
    axil_arvalid = 0;
    ok = done;
    lat = 1;
    while (!axil_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!axil_rvalid) ok = 0;
    data = axil_rdata; resp = axil_rresp;
    axil_rready = 1;
    @(posedge clk); #1;
    axil_rready = 0;
  endtask

  typedef struct {
    bit wr; int ord; logic [15:0] a; logic [31:0] d; logic [3:0] s; int bdly; int dly; logic [31:0] exp;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vt [10];
    logic [31:0] data;
    logic [1:0] resp;
    int lat, p0;
    bit ok, st;
    vt[0] = '{1'b0, 0, 16'h0, 32'h0,        4'h0, 0, 0, 32'h00000000};
    vt[1] = '{1'b0, 0, 16'h4, 32'h0,        4'h0, 0, 0, 32'h00ffff00};
    vt[2] = '{1'b1, 0, 16'h0, 32'hdeadbeef, 4'hf, 0, 0, 32'h0};
    vt[3] = '{1'b0, 0, 16'h0, 32'h0,        4'h0, 0, 1, 32'hdeadbeef};
    vt[4] = '{1'b1, 1, 16'h0, 32'h66778899, 4'h6, 0, 0, 32'h0};
    vt[5] = '{1'b0, 0, 16'h0, 32'h0,        4'h0, 0, 2, 32'hde7788ef};
    vt[6] = '{1'b1, 2, 16'h4, 32'hdeadbeef, 4'hf, 0, 3, 32'h0};
    vt[7] = '{1'b1, 0, 16'h4, 32'h66778899, 4'h2, 5, 0, 32'h0};
    vt[8] = '{1'b0, 0, 16'h4, 32'h0,        4'h0, 0, 3, 32'h00ad8800};
    vt[9] = '{1'b0, 0, 16'h8, 32'h0,        4'h0, 0, 0, 32'h00000000};
    mdl = '{32'h0, 32'h00ffff00};
    axil_awaddr = 0; axil_awvalid = 0; axil_wdata = 0; axil_wstrb = 0; axil_wvalid = 0; axil_bready = 0;
    axil_araddr = 0; axil_arvalid = 0; axil_rready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {axil_awready, axil_wready, axil_arready, axil_bvalid, axil_rvalid, lb_wen, lb_ren, axil_bresp, axil_rresp}, 0);
    chk("reset_data", {axil_rdata, lb_wdata}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_after_reset", {axil_awready, axil_wready, axil_arready}, 3'b111);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        p0 = pulses; wdly = vt[i].dly;
        do_write(vt[i].a, vt[i].d, vt[i].s, vt[i].ord, vt[i].bdly, resp, lat, ok, st);
        chk($sformatf("vec%0d_wr_done", i), ok, 1);
        chk($sformatf("vec%0d_bresp", i), resp, 0);
        chk($sformatf("vec%0d_wr_lat", i), lat, 2 + vt[i].dly);
        chk($sformatf("vec%0d_wen_pulses", i), pulses - p0, 1);
        if (vt[i].bdly > 0) chk($sformatf("vec%0d_stall", i), st, 1);
        mdl[vt[i].a[2]] = merge(mdl[vt[i].a[2]], vt[i].d, vt[i].s, vt[i].a);
        exp_pulses++;
      end else begin
        rdly = vt[i].dly;
        do_read(vt[i].a, data, resp, lat, ok);
        chk($sformatf("vec%0d_rd_done", i), ok, 1);
        chk($sformatf("vec%0d_rdata", i), data, vt[i].exp);
        chk($sformatf("vec%0d_rresp", i), resp, 0);
        chk($sformatf("vec%0d_rd_lat", i), lat, 2 + vt[i].dly);
      end
    end
    wdly = 0; rdly = 0;

    spur = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("spurious_ignored", {axil_bvalid, axil_rvalid, lb_wen, lb_ren}, 0);
    end
    spur = 0;

    axil_awaddr = 16'h0; axil_wdata = 32'h13572468; axil_wstrb = 4'hf; axil_araddr = 16'h4;
    axil_awvalid = 1; axil_wvalid = 1; axil_arvalid = 1; axil_bready = 1; axil_rready = 1;
    @(posedge clk); #1;
    axil_awvalid = 0; axil_wvalid = 0; axil_arvalid = 0;
    chk("conc_en", {lb_wen, lb_ren}, 2'b11);
    @(posedge clk); #1;
    chk("conc_resp", {axil_bvalid, axil_rvalid, axil_bresp, axil_rresp}, 6'b110000);
    chk("conc_rdata", axil_rdata, mdl[1]);
    mdl[0] = merge(mdl[0], 32'h13572468, 4'hf, 16'h0);
    exp_pulses++;
    @(posedge clk); #1;
    chk("conc_done", {axil_bvalid, axil_rvalid, axil_awready, axil_arready}, 4'b0011);
    axil_bready = 0; axil_rready = 0;

    stuck = 1;
    do_read(16'h4, data, resp, lat, ok);
    chk("tmo_rd_done", ok, 1);
    chk("tmo_rd_lat", lat, TO + 1);
    chk("tmo_rresp", resp, 2'b10);
    chk("tmo_rdata", data, 0);
    p0 = pulses;
    do_write(16'h0, 32'h12345678, 4'hf, 0, 0, resp, lat, ok, st);
    chk("tmo_wr_done", ok, 1);
    chk("tmo_wr_lat", lat, TO + 1);
    chk("tmo_bresp", resp, 2'b10);
    chk("tmo_no_pulse", pulses - p0, 0);

    axil_awaddr = 16'h4; axil_wdata = 32'hffffffff; axil_wstrb = 4'hf;
    axil_awvalid = 1; axil_wvalid = 1;
    @(posedge clk); #1;
    axil_awvalid = 0; axil_wvalid = 0;
    chk("rst_pre_wen", lb_wen, 1);
    #2 rst = 1;
    #1 chk("rst_async_wen", {lb_wen, axil_bvalid}, 2'b00);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_bvalid", {axil_bvalid, lb_wen}, 2'b00);
    end
    stuck = 0;

    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      logic [31:0] d, exp;
      logic [3:0] s;
      int dly;
      a = 16'($urandom_range(0, 2) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      dly = $urandom_range(0, TO - 1);
      if ($urandom_range(0, 1) == 1) begin
        p0 = pulses; wdly = dly;
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat, ok, st);
        chk($sformatf("rnd%0d_wr", n), {ok, st, resp}, 4'b1100);
        chk($sformatf("rnd%0d_wr_lat", n), lat, 2 + dly);
        chk($sformatf("rnd%0d_wen_pulses", n), pulses - p0, 1);
        if (a != 16'h8) mdl[a[2]] = merge(mdl[a[2]], d, s, a);
        exp_pulses++;
      end else begin
        rdly = dly;
        exp = a == 16'h8 ? 32'h0 : mdl[a[2]];
        do_read(a, data, resp, lat, ok);
        chk($sformatf("rnd%0d_rd", n), {ok, resp}, 3'b100);
        chk($sformatf("rnd%0d_rdata", n), data, exp);
        chk($sformatf("rnd%0d_rd_lat", n), lat, 2 + dly);
      end
    end
    chk("pulse_total", pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axil2lb.md
Name: axil2lb

Overview:
- AXI4-Lite slave to Local Bus master bridge.
- Sits directly upstream of the generated register map `regs`, as an alternative front end to the APB bridge.
- Converts AXI4-Lite write/read transactions into Local Bus `wen`/`ren` accesses and returns responses.
- Write and read paths are independent and may run concurrently.

Parameters:
- ADDR_W, 16, address width of AXI and Local Bus.
- DATA_W, 32, data width (multiple of 8).
- STRB_W, DATA_W/8, byte strobe width.
- TIMEOUT, 255, max cycles waiting for lb_wready/lb_rvalid before SLVERR; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- axil_awaddr / awvalid / awready  in/in/out  ADDR_W/1/1  write address channel
- axil_wdata / wstrb / wvalid / wready  in/in/in/out  DATA_W/STRB_W/1/1  write data channel
- axil_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- axil_araddr / arvalid / arready  in/in/out  ADDR_W/1/1  read address channel
- axil_rdata / rresp / rvalid / rready  out/out/out/in  DATA_W/2/1/1  read data channel
- lb_waddr / wdata / wstrb / wen  out  ADDR_W/DATA_W/STRB_W/1  Local Bus write request
- lb_wready  input  1  regmap accepts write this cycle
- lb_raddr / ren  out  ADDR_W/1  Local Bus read request
- lb_rdata / rvalid  input  DATA_W/1  read data, valid when lb_rvalid=1

Behaviour:
- Reset: all outputs 0; both FSMs in IDLE; captured AW/W flags cleared.
- Write FSM states: W_IDLE, W_LB, W_RESP.
- W_IDLE:
  - awready=1 while AW not yet captured; wready=1 while W not yet captured.
  - AW and W are captured independently, in either order or in the same cycle.
  - When both are held (including the capture cycle), go to W_LB next cycle.
- W_LB:
  - lb_wen=1 with captured waddr/wdata/wstrb, held stable.
  - lb_wready=1 ends the access → W_RESP, bresp=OKAY(00).
  - Counter reaching TIMEOUT with no lb_wready → W_RESP, bresp=SLVERR(10), lb_wen deasserts.
- W_RESP: bvalid=1 until bready; → W_IDLE; capture flags cleared.
- Write latency: AW+W at cycle 0, lb_wready tied high → lb_wen at cycle 1, bvalid at cycle 2.
- Read FSM states: R_IDLE, R_LB, R_RESP.
- R_IDLE: arready=1; arvalid captures araddr → R_LB.
- R_LB:
  - lb_ren=1, lb_raddr stable.
  - First lb_rvalid=1 latches lb_rdata → R_RESP, rresp=OKAY.
  - Timeout → rdata=0, rresp=SLVERR.
- R_RESP: rvalid=1, rdata/rresp stable until rready; → R_IDLE.
- Read latency: AR at cycle 0, regmap rvalid in the same cycle as ren → lb_ren at cycle 1, axil_rvalid at cycle 2.
- lb_wen and lb_ren are each high only in their LB state; simultaneous write and read are allowed on separate LB ports.
- Timeout counter: clog2(TIMEOUT+1) bits; cleared on LB state entry; saturating.
- A lb_wready/lb_rvalid arriving in the timeout cycle wins (OKAY).
- Spurious lb_wready/lb_rvalid outside the LB states is ignored.
- bready/rready may already be high on entry to the RESP state: single-cycle handshake, next transaction accepted the following cycle.
- No new AW/W is accepted while in W_LB or W_RESP; no new AR while in R_LB or R_RESP (one outstanding per direction).
- Reset mid-transaction: immediate return to IDLE, all handshake outputs 0, the transaction is dropped.

Test Plan:
- Read after reset, with regs behind the bridge:
  - read 0x0 → rdata=0x00000000, rresp=00.
  - read 0x4 → rdata=0x00ffff00.
- Write 0x0 data 0xdeadbeef strb 0xF, AW and W in the same cycle → bvalid at cycle 2, bresp=00; readback 0xdeadbeef.
- W one cycle before AW, data 0x66778899 strb 0b0110 to 0x0 → single lb_wen pulse; readback 0xde7788ef.
- Write 0x4 with 0xdeadbeef, then strb 0b0010 data 0x66778899, with bready held low 5 cycles:
  - bvalid stays high 5 cycles and no new awready during the stall.
  - readback 0x00ad8800.
- Concurrent write 0x0 and read 0x4 issued in the same cycle → lb_wen and lb_ren both high at cycle 1; both complete OKAY.
- TIMEOUT=4, stub with lb_rvalid/lb_wready stuck low:
  - read → rvalid 5 cycles after the ar handshake, rresp=10, rdata=0.
  - write → bresp=10.
  - rst pulse asserted mid-W_LB → lb_wen drops asynchronously, bvalid stays 0.
